// File: rtl/icache_ctrl_rv32_if.sv
// Fetch-side and memory-side signal bundle for the RV32I instruction cache controller.
// The iFLUSH wire exists only when ICACHE_FLUSH_EN is defined.
interface icache_ctrl_rv32_if;
   logic        iREQ;
   logic [31:0] iINSTADDR;
   logic [31:0] oINSTDATA;
   logic        oStallI;
   logic        oMEMREQ;
   logic [31:0] oMEMADDR;
   logic        iMEMACK;
   logic [31:0] iMEMDATA;
`ifdef ICACHE_FLUSH_EN
   logic        iFLUSH;
`endif

   // Cache controller side
   modport slave (
      input  iREQ, iINSTADDR, iMEMACK, iMEMDATA,
`ifdef ICACHE_FLUSH_EN
      input  iFLUSH,
`endif
      output oINSTDATA, oStallI, oMEMREQ, oMEMADDR
   );

   // Core / memory model side
   modport master (
      output iREQ, iINSTADDR, iMEMACK, iMEMDATA,
`ifdef ICACHE_FLUSH_EN
      output iFLUSH,
`endif
      input  oINSTDATA, oStallI, oMEMREQ, oMEMADDR
   );
endinterface

// File: rtl/icache_ctrl_rv32.sv
// Direct-mapped, one-word-per-line instruction cache controller for the RV32I fetch stage.
// Hits return data one cycle after the request; a miss stalls the core and issues a
// single-word refill to instruction memory.
// Optional feature macro: ICACHE_FLUSH_EN (adds iFLUSH and a line-by-line invalidate walk).
module icache_ctrl_rv32 #(
   parameter int LINES = 8
) (
   input logic                iCLK,
   input logic                iRSTn,
   icache_ctrl_rv32_if.slave  bus
);
   localparam int IDXW = $clog2(LINES);
   localparam int TAGW = 30 - IDXW;

`ifdef ICACHE_FLUSH_EN
   typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, FLUSH = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1} state_t;
`endif

   state_t state, stateNxt;

   logic [LINES-1:0] valid;
   logic [TAGW-1:0]  tagArr  [LINES];
   logic [31:0]      dataArr [LINES];

   logic [IDXW-1:0]  idx;
   logic [TAGW-1:0]  tag;
   logic             hit;
   logic             ackRefill;
   logic             missStart;
   logic [31:0]      memAddrQ;
   logic [31:0]      instDataQ;
   logic [IDXW-1:0]  refIdx;
   logic [TAGW-1:0]  refTag;
   logic             memReq;
   logic             stall;
   logic [1:0]       unusedAddrBits;

`ifdef ICACHE_FLUSH_EN
   logic             flushPend;
   logic [IDXW-1:0]  flushCnt;
   logic             flushLast;
`endif

   assign idx            = bus.iINSTADDR[IDXW+1:2];
   assign tag            = bus.iINSTADDR[31:IDXW+2];
   assign unusedAddrBits = bus.iINSTADDR[1:0];

   // The refill line is addressed from the captured request, not the live fetch address
   assign refIdx    = memAddrQ[IDXW+1:2];
   assign refTag    = memAddrQ[31:IDXW+2];

   assign hit       = bus.iREQ & valid[idx] & (tagArr[idx] == tag);
   assign ackRefill = (state == REFILL) & bus.iMEMACK;
   assign missStart = (state == IDLE) & (stateNxt == REFILL);

`ifdef ICACHE_FLUSH_EN
   assign flushLast = (flushCnt == IDXW'(LINES - 1));
`endif

   // State register
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) state <= IDLE;
      else        state <= stateNxt;
   end

   // Next-state decode: flush beats miss in IDLE; a pending flush follows the refill
   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: begin
`ifdef ICACHE_FLUSH_EN
            if (bus.iFLUSH)                stateNxt = FLUSH;
            else if (bus.iREQ && !hit)     stateNxt = REFILL;
`else
            if (bus.iREQ && !hit)          stateNxt = REFILL;
`endif
         end
         REFILL: begin
`ifdef ICACHE_FLUSH_EN
            if (bus.iMEMACK)               stateNxt = (flushPend || bus.iFLUSH) ? FLUSH : IDLE;
`else
            if (bus.iMEMACK)               stateNxt = IDLE;
`endif
         end
`ifdef ICACHE_FLUSH_EN
         FLUSH: begin
            if (flushLast)                 stateNxt = IDLE;
         end
`endif
         default:                          stateNxt = IDLE;
      endcase
   end

   // Output decode: memory request is a level for the whole refill, stall is same-cycle
   always_comb begin
      memReq = (state == REFILL);
      stall  = (state != IDLE) | (bus.iREQ & ~hit);
   end

   assign bus.oMEMREQ   = memReq;
   assign bus.oStallI   = stall;
   assign bus.oMEMADDR  = memAddrQ;
   assign bus.oINSTDATA = instDataQ;

   // Capture the word address of the missing fetch; it stays put until the ack
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)         memAddrQ <= '0;
      else if (missStart) memAddrQ <= {bus.iINSTADDR[31:2], 2'b00};
   end

   // Registered instruction output, updated only by an IDLE hit
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)                     instDataQ <= '0;
      else if (state == IDLE && hit)  instDataQ <= dataArr[idx];
   end

   // Valid bits: set by refill, cleared by reset or the flush walk
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         valid <= '0;
      end else begin
         if (ackRefill) valid[refIdx] <= 1'b1;
`ifdef ICACHE_FLUSH_EN
         if (state == FLUSH) valid[flushCnt] <= 1'b0;
`endif
      end
   end

   // Tag and data storage need no reset; valid bits gate every use
   always_ff @(posedge iCLK) begin
      if (ackRefill) begin
         tagArr[refIdx]  <= refTag;
         dataArr[refIdx] <= bus.iMEMDATA;
      end
   end

`ifdef ICACHE_FLUSH_EN
   // Remember a flush request that arrives while a refill is outstanding
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)                               flushPend <= 1'b0;
      else if (state == FLUSH)                  flushPend <= 1'b0;
      else if (state == REFILL && bus.iFLUSH)   flushPend <= 1'b1;
   end

   // Flush walk index; wraps back to zero on the last line so the next flush starts clean
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)              flushCnt <= '0;
      else if (state == FLUSH) flushCnt <= flushCnt + 1'b1;
   end
`endif

endmodule
